vmac_sched: RTL and testbench
=============================

VMAC_SCHED -- requirements
Module: vmac_sched

Interface
REQ-001 Parameter MULADD_OP, default 5, is the operation code that identifies a vector multiply-add instruction.
REQ-002 Parameter TIMEOUT, default 16, is the maximum number of RUN cycles allowed before a missing mac_done is flagged.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 ext_stall  input  1  pipeline stall from downstream stages.
REQ-006 issue_valid  input  1  an instruction is presented for execute.
REQ-007 issue_op  input  4  operation code of the presented instruction.
REQ-008 issue_is_v  input  1  the presented instruction is a vector instruction.
REQ-009 issue_vd, issue_vs1, issue_vs2, issue_vs3  input  5 each  vector register indices of the presented instruction.
REQ-010 issue_ready  output  1  execute may accept the presented instruction this cycle.
REQ-011 stall_o  output  1  hazard stall request toward fetch/decode.
REQ-012 mac_valid  output  1  one-cycle start pulse to the multiply-add unit.
REQ-013 mac_done  input  1  multiply-add unit has finished.
REQ-014 wb_valid  output  1  multiply-add result is ready for vector writeback.
REQ-015 wb_vd  output  5  destination register for the writeback.
REQ-016 busy  output  1  a multiply-add is in flight.
REQ-017 err  output  1  sticky protocol-error flag.
REQ-018 clr_err  input  1  clears err.

Function
REQ-019 The FSM SHALL have the states IDLE, RUN and DONE, and busy SHALL equal (state != IDLE).
REQ-020 An instruction is accepted when issue_valid, issue_ready and !ext_stall are all high.
REQ-021 In IDLE, issue_ready SHALL be 1.
REQ-022 In RUN and DONE, issue_ready SHALL be 0 if either condition below holds, and 1 otherwise.
- issue_op == MULADD_OP.
- issue_is_v is high and any of vd, vs1, vs2 or vs3 equals pend_vd (RAW/WAW/WAR hazard).
REQ-023 stall_o SHALL be combinational and equal issue_valid & !issue_ready.
REQ-024 When a MULADD_OP instruction is accepted in IDLE, the block SHALL capture pend_vd <= issue_vd, clear cnt to 0 and enter RUN.
REQ-025 mac_valid SHALL be high for exactly the first RUN cycle, one cycle after acceptance.
REQ-026 In RUN, cnt SHALL increment every cycle regardless of ext_stall.
REQ-027 A mac_done that arrives in the same cycle mac_valid is high SHALL be ignored.
REQ-028 In RUN, mac_done SHALL cause a transition to DONE on the next edge.
REQ-029 If cnt == TIMEOUT-1 in RUN and mac_done is low, the block SHALL set err and return to IDLE without issuing a writeback.
REQ-030 In DONE, wb_valid SHALL be 1 and wb_vd SHALL equal pend_vd.
REQ-031 DONE SHALL exit to IDLE on the first cycle in which ext_stall is low, so wb_valid is held while ext_stall is high.
REQ-032 wb_valid SHALL be 0 outside DONE.
REQ-033 wb_vd SHALL hold its last value outside DONE.
REQ-034 A mac_done received in IDLE or DONE SHALL set err and SHALL NOT change state.
REQ-035 clr_err SHALL clear err on the next edge; if a set and a clear occur in the same cycle, the set wins.
REQ-036 cnt SHALL be ceil(log2(TIMEOUT))+1 bits wide and SHALL saturate rather than wrap.
REQ-037 Non-MAC instructions SHALL pass through with no state change and no added latency when issue_ready is high.

Reset
REQ-038 While rst is low, the following SHALL be forced asynchronously.
- state = IDLE.
- pend_vd = 0, cnt = 0.
- mac_valid = 0, wb_valid = 0, wb_vd = 0, err = 0.
- busy = 0, so issue_ready = 1 and stall_o = 0.
REQ-039 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no writeback, and any later mac_done SHALL be treated as spurious (REQ-034).

Verification
REQ-040 MAC with vd=3 accepted at cycle 0 and mac_done at cycle 4 -> mac_valid high at cycle 1 only, wb_valid=1 with wb_vd=3 at cycle 5, busy=0 at cycle 6.
REQ-041 While a MAC with vd=3 is running, present a vector add with vs2=3 -> issue_ready=0 and stall_o=1 until DONE exits; a vector add using only v5 is accepted immediately.
REQ-042 A second MULADD_OP presented while in RUN -> stalled; it is accepted in the cycle after DONE exits.
REQ-043 With TIMEOUT=16 and no mac_done -> err=1 and state IDLE after 16 RUN cycles, wb_valid never asserted; pulsing clr_err -> err=0.
REQ-044 ext_stall held high for 3 cycles on entry to DONE -> wb_valid stays high for 4 cycles with a stable wb_vd.
REQ-045 Reset pulsed low in RUN, then mac_done -> all outputs 0 immediately on reset, and err=1 after the spurious mac_done.

Source files
------------

// File: rtl/vmac_sched.sv
// Issue scheduler for a vector multiply-add unit: it tracks the one MAC in flight,
// stalls hazarding instructions, and sequences start, completion and writeback.
module vmac_sched #(
    parameter int MULADD_OP = 5,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_stall,
    input  logic       issue_valid,
    input  logic [3:0] issue_op,
    input  logic       issue_is_v,
    input  logic [4:0] issue_vd,
    input  logic [4:0] issue_vs1,
    input  logic [4:0] issue_vs2,
    input  logic [4:0] issue_vs3,
    output logic       issue_ready,
    output logic       stall_o,
    output logic       mac_valid,
    input  logic       mac_done,
    output logic       wb_valid,
    output logic [4:0] wb_vd,
    output logic       busy,
    output logic       err,
    input  logic       clr_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       OP_MAC   = 4'(MULADD_OP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_pend_vd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mac_valid;
    logic [4:0]       r_wb_vd;
    logic             r_err;

    logic w_is_mac;
    logic w_hazard;
    logic w_ready;
    logic w_accept;
    logic w_start;
    logic w_done_ok;
    logic w_timeout;
    logic w_err_set;

    always_comb begin
        w_is_mac  = (issue_op == OP_MAC);
        w_hazard  = issue_is_v && ((issue_vd  == r_pend_vd) || (issue_vs1 == r_pend_vd) ||
                                   (issue_vs2 == r_pend_vd) || (issue_vs3 == r_pend_vd));
        w_ready   = (r_state == IDLE) ? 1'b1 : !(w_is_mac || w_hazard);
        w_accept  = issue_valid && w_ready && !ext_stall;
        w_start   = (r_state == IDLE) && w_accept && w_is_mac;
        // A done coinciding with the start pulse cannot belong to this operation.
        w_done_ok = (r_state == RUN) && mac_done && !r_mac_valid;
        w_timeout = (r_state == RUN) && !w_done_ok && (r_cnt == CNT_LAST);
        w_err_set = w_timeout || (mac_done && (r_state != RUN));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = RUN;
            RUN: begin
                if (w_done_ok)      w_state_nxt = DONE;
                else if (w_timeout) w_state_nxt = IDLE;
            end
            DONE: if (!ext_stall) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_pend_vd   <= '0;
            r_cnt       <= '0;
            r_mac_valid <= 1'b0;
            r_wb_vd     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mac_valid <= w_start;
            if (w_start) begin
                r_pend_vd <= issue_vd;
                r_cnt     <= '0;
            end else if ((r_state == RUN) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done_ok)
                r_wb_vd <= r_pend_vd;
            // Set has priority over clear.
            if (w_err_set)
                r_err <= 1'b1;
            else if (clr_err)
                r_err <= 1'b0;
        end
    end

    assign issue_ready = w_ready;
    assign stall_o     = issue_valid & !w_ready;
    assign mac_valid   = r_mac_valid;
    assign wb_valid    = (r_state == DONE);
    assign wb_vd       = r_wb_vd;
    assign busy        = (r_state != IDLE);
    assign err         = r_err;

endmodule

// File: tb/tb_vmac_sched.sv
// Self-checking bench for vmac_sched: expected writeback registers are queued at
// MAC acceptance and popped when wb_valid rises.
module tb_vmac_sched;

    localparam int MULADD_OP = 5;
    localparam int TIMEOUT   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ext_stall = 1'b0;
    logic       issue_valid = 1'b0;
    logic [3:0] issue_op = 4'd0;
    logic       issue_is_v = 1'b0;
    logic [4:0] issue_vd = 5'd0, issue_vs1 = 5'd0, issue_vs2 = 5'd0, issue_vs3 = 5'd0;
    logic       mac_done = 1'b0;
    logic       clr_err = 1'b0;
    logic       issue_ready, stall_o, mac_valid, wb_valid, busy, err;
    logic [4:0] wb_vd;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_vd;

    vmac_sched #(.MULADD_OP(MULADD_OP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ext_stall(ext_stall),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_is_v(issue_is_v),
        .issue_vd(issue_vd), .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vs3(issue_vs3),
        .issue_ready(issue_ready), .stall_o(stall_o), .mac_valid(mac_valid),
        .mac_done(mac_done), .wb_valid(wb_valid), .wb_vd(wb_vd),
        .busy(busy), .err(err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [3:0] op, input logic isv,
                           input logic [4:0] vd, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] s3);
        issue_valid = v; issue_op = op; issue_is_v = isv;
        issue_vd = vd; issue_vs1 = s1; issue_vs2 = s2; issue_vs3 = s3;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        present(1'b1, 4'(MULADD_OP), 1'b1, 5'd1, 5'd2, 5'd3, 5'd4);
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (mac_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mac_valid: got %b want 0", mac_valid); end
        n_checks++; if (wb_valid !== 1'b0 || wb_vd !== 5'd0) begin n_fail++; $display("FAIL reset_wb: got valid=%b vd=%0d want 0/0", wb_valid, wb_vd); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (issue_ready !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got ready=%b stall=%b want 1/0", issue_ready, stall_o); end
        present(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        // Non-MAC instruction in IDLE: accepted with no state change.
        present(1'b1, 4'd2, 1'b1, 5'd3, 5'd3, 5'd3, 5'd3);
        #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL passthru_ready: got %b want 1", issue_ready); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL passthru_busy: got %b want 0", busy); end
        present(1'b1, 4'(MULADD_OP), 1'b1, 5'd3, 5'd1, 5'd2, 5'd0);
        #1;
        n_checks++; if (issue_ready !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL basic_accept: got ready=%b stall=%b want 1/0", issue_ready, stall_o); end
        exp_q.push_back(5'd3);
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (mac_valid !== (c == 1)) begin n_fail++; $display("FAIL basic_mac_valid_c%0d: got %b want %b", c, mac_valid, (c == 1)); end
            if (c == 1) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
            end
            tick();
            present(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
            mac_done = (c == 3);
        end
        mac_done = 1'b0;
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL basic_wb: got wb_valid=%b queued=%0d want 1 with entry", wb_valid, exp_q.size()); end
        else begin exp_vd = exp_q.pop_front(); if (wb_vd !== exp_vd) begin n_fail++; $display("FAIL basic_wb_vd: got %0d want %0d", wb_vd, exp_vd); end end
        tick();
        n_checks++; if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_vd !== 5'd3) begin n_fail++; $display("FAIL basic_end: got busy=%b wb=%b vd=%0d want 0/0/3", busy, wb_valid, wb_vd); end
    endtask

    task automatic test_done_on_start();
        present(1'b1, 4'(MULADD_OP), 1'b0, 5'd10, 5'd0, 5'd0, 5'd0);
        exp_q.push_back(5'd10);
        tick();
        present(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b1 || wb_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL early_done: got busy=%b wb=%b err=%b want 1/0/0", busy, wb_valid, err); end
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL early_wb: got wb_valid=%b queued=%0d want 1 with entry", wb_valid, exp_q.size()); end
        else begin exp_vd = exp_q.pop_front(); if (wb_vd !== exp_vd) begin n_fail++; $display("FAIL early_wb_vd: got %0d want %0d", wb_vd, exp_vd); end end
        tick();
    endtask

    task automatic test_hazard();
        present(1'b1, 4'(MULADD_OP), 1'b1, 5'd3, 5'd0, 5'd1, 5'd2);
        exp_q.push_back(5'd3);
        tick();
        present(1'b1, 4'd1, 1'b1, 5'd7, 5'd8, 5'd3, 5'd9);
        #1;
        n_checks++; if (issue_ready !== 1'b0 || stall_o !== 1'b1) begin n_fail++; $display("FAIL hazard_vs2: got ready=%b stall=%b want 0/1", issue_ready, stall_o); end
        present(1'b1, 4'd1, 1'b1, 5'd3, 5'd8, 5'd8, 5'd9);
        #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_vd: got ready=%b want 0", issue_ready); end
        present(1'b1, 4'd1, 1'b0, 5'd3, 5'd3, 5'd3, 5'd3);
        #1;
        n_checks++; if (issue_ready !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL hazard_scalar: got ready=%b stall=%b want 1/0", issue_ready, stall_o); end
        tick();
        present(1'b1, 4'd1, 1'b1, 5'd5, 5'd5, 5'd5, 5'd5);
        #1;
        n_checks++; if (issue_ready !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL hazard_v5: got ready=%b stall=%b want 1/0", issue_ready, stall_o); end
        tick();
        present(1'b1, 4'd1, 1'b1, 5'd7, 5'd8, 5'd3, 5'd9);
        mac_done = 1'b1;
        #1;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL hazard_run_stall: got %b want 1", stall_o); end
        tick();
        mac_done = 1'b0;
        #1;
        n_checks++; if (issue_ready !== 1'b0 || stall_o !== 1'b1) begin n_fail++; $display("FAIL hazard_done_stall: got ready=%b stall=%b want 0/1", issue_ready, stall_o); end
        n_checks++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL hazard_wb: got wb_valid=%b queued=%0d want 1 with entry", wb_valid, exp_q.size()); end
        else begin exp_vd = exp_q.pop_front(); if (wb_vd !== exp_vd) begin n_fail++; $display("FAIL hazard_wb_vd: got %0d want %0d", wb_vd, exp_vd); end end
        tick();
        n_checks++; if (issue_ready !== 1'b1 || stall_o !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hazard_release: got ready=%b stall=%b busy=%b want 1/0/0", issue_ready, stall_o, busy); end
        present(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_back_to_back();
        present(1'b1, 4'(MULADD_OP), 1'b1, 5'd4, 5'd0, 5'd1, 5'd2);
        exp_q.push_back(5'd4);
        tick();
        present(1'b1, 4'(MULADD_OP), 1'b1, 5'd6, 5'd10, 5'd11, 5'd12);
        #1;
        n_checks++; if (issue_ready !== 1'b0 || stall_o !== 1'b1) begin n_fail++; $display("FAIL b2b_run_stall: got ready=%b stall=%b want 0/1", issue_ready, stall_o); end
        tick();
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_stall: got ready=%b want 0", issue_ready); end
        n_checks++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_wb1: got wb_valid=%b queued=%0d want 1 with entry", wb_valid, exp_q.size()); end
        else begin exp_vd = exp_q.pop_front(); if (wb_vd !== exp_vd) begin n_fail++; $display("FAIL b2b_wb1_vd: got %0d want %0d", wb_vd, exp_vd); end end
        tick();
        n_checks++; if (issue_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got ready=%b busy=%b want 1/0", issue_ready, busy); end
        exp_q.push_back(5'd6);
        tick();
        present(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++; if (mac_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_mac_valid: got %b want 1", mac_valid); end
        tick();
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_wb2: got wb_valid=%b queued=%0d want 1 with entry", wb_valid, exp_q.size()); end
        else begin exp_vd = exp_q.pop_front(); if (wb_vd !== exp_vd) begin n_fail++; $display("FAIL b2b_wb2_vd: got %0d want %0d", wb_vd, exp_vd); end end
        tick();
    endtask

    task automatic test_wb_stall();
        present(1'b1, 4'(MULADD_OP), 1'b1, 5'd12, 5'd0, 5'd0, 5'd0);
        exp_q.push_back(5'd12);
        tick();
        present(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        ext_stall = 1'b1;
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL stall_wb: got wb_valid=%b queued=%0d want 1 with entry", wb_valid, exp_q.size()); end
        else begin exp_vd = exp_q.pop_front(); if (wb_vd !== exp_vd) begin n_fail++; $display("FAIL stall_wb_vd: got %0d want %0d", wb_vd, exp_vd); end end
        for (int i = 0; i < 4; i++) begin
            ext_stall = (i < 3);
            #1;
            n_checks++; if (wb_valid !== 1'b1 || wb_vd !== 5'd12) begin n_fail++; $display("FAIL stall_hold_%0d: got wb=%b vd=%0d want 1/12", i, wb_valid, wb_vd); end
            tick();
        end
        n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_exit: got wb=%b busy=%b want 0/0", wb_valid, busy); end
    endtask

    task automatic test_timeout();
        present(1'b1, 4'(MULADD_OP), 1'b1, 5'd2, 5'd0, 5'd0, 5'd0);
        tick();
        present(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            n_checks++; if (busy !== 1'b1 || err !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_run_%0d: got busy=%b err=%b wb=%b want 1/0/0", i, busy, err, wb_valid); end
            tick();
        end
        n_checks++; if (busy !== 1'b0 || err !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_end: got busy=%b err=%b wb=%b want 0/1/0", busy, err, wb_valid); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_clr: got %b want 0", err); end
        clr_err = 1'b1;
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        #1;
        n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL set_wins: got err=%b busy=%b want 1/0", err, busy); end
        tick();
        clr_err = 1'b0;
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL set_wins_clr: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_run();
        present(1'b1, 4'(MULADD_OP), 1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
        tick();
        #1;
        n_checks++; if (mac_valid !== 1'b1 || stall_o !== 1'b1) begin n_fail++; $display("FAIL rstrun_pre: got mac_valid=%b stall=%b want 1/1", mac_valid, stall_o); end
        rst = 1'b0;
        #1;
        n_checks++; if (mac_valid !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0 || wb_vd !== 5'd0 || err !== 1'b0) begin n_fail++; $display("FAIL rstrun_outs: got mv=%b busy=%b wb=%b vd=%0d err=%b want all 0", mac_valid, busy, wb_valid, wb_vd, err); end
        n_checks++; if (issue_ready !== 1'b1 || stall_o !== 1'b0) begin n_fail++; $display("FAIL rstrun_ready: got ready=%b stall=%b want 1/0", issue_ready, stall_o); end
        tick();
        present(1'b0, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        rst = 1'b1;
        tick();
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
        #1;
        n_checks++; if (err !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstrun_spurious: got err=%b busy=%b wb=%b want 1/0/0", err, busy, wb_valid); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_on_start();
        test_hazard();
        test_back_to_back();
        test_wb_stall();
        test_timeout();
        test_reset_mid_run();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
